// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one request/ack memory port between fetch and data access, DM-priority with IF starvation guard and timeout.
// Optional ARB_PERF_CNT_EN adds saturating grant/stall performance counters.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_dm_grants,
    output logic [31:0]       perf_stall_cycles
`endif
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;
    state_t      state_q;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  tmo_q;
    logic        dm_win, if_win, tmo_done;

    assign if_stall = if_req && !if_valid;
    assign dm_stall = dm_req && !dm_valid;

    always_comb begin
        dm_win   = dm_req && !(if_req && wait_q == 4'(MAX_WAIT));
        if_win   = if_req && !dm_win;
        wait_d   = if_win ? 4'd0 : (dm_win && if_req) ? wait_q + 4'd1 : wait_q;
        tmo_done = tmo_q == 8'(TIMEOUT - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            tmo_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_win || dm_win) begin
                        state_q   <= dm_win ? BUSY_DM : BUSY_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_win && dm_we;
                        mem_addr  <= dm_win ? dm_addr : if_addr;
                        mem_wdata <= dm_win ? dm_wdata : '0;
                        wait_q    <= wait_d;
                        tmo_q     <= '0;
                    end
                end
                default: begin
                    if (mem_ack || tmo_done) begin
                        // mem_ack takes precedence over a coincident timeout
                        state_q <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        bus_err <= bus_err || !mem_ack;
                        if (state_q == BUSY_IF) begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            dm_valid <= 1'b1;
                            if (!mem_ack || !mem_we)
                                dm_rdata <= mem_ack ? mem_rdata : '0;
                        end
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_grants    <= '0;
            perf_dm_grants    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (state_q == IDLE && if_win)
                perf_if_grants <= perf_if_grants + 32'(perf_if_grants != '1);
            if (state_q == IDLE && dm_win)
                perf_dm_grants <= perf_dm_grants + 32'(perf_dm_grants != '1);
            if (if_stall || dm_stall)
                perf_stall_cycles <= perf_stall_cycles + 32'(perf_stall_cycles != '1);
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_valid, if_stall, dm_valid, dm_stall, mem_req, mem_we, bus_err;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_grants, perf_dm_grants, perf_stall_cycles;
`endif
    int checks = 0;
    int failures = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
`ifdef ARB_PERF_CNT_EN
        , .perf_if_grants(perf_if_grants), .perf_dm_grants(perf_dm_grants),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] arb_addr [6] = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h40, 32'h300};

    initial begin
        tick();
        tick();
        chk("rst_mem_req", {31'b0, mem_req}, 0);
        chk("rst_valids", {30'b0, if_valid, dm_valid}, 0);
        chk("rst_bus_err", {31'b0, bus_err}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        mem_ack = 1'b1;
        tick();
        chk("idle_ack_ignored", {29'b0, mem_req, if_valid, dm_valid}, 0);
        mem_ack = 1'b0;

        // fetch with zero-wait memory
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        chk("if_mem_req", {31'b0, mem_req}, 1);
        chk("if_mem_addr", mem_addr, 32'h10);
        chk("if_mem_we", {31'b0, mem_we}, 0);
        chk("if_mem_wdata", mem_wdata, 0);
        chk("if_stall_busy", {31'b0, if_stall}, 1);
        mem_ack = 1'b1; mem_rdata = 32'h0051_0113;
        tick();
        chk("if_valid", {31'b0, if_valid}, 1);
        chk("if_rdata", if_rdata, 32'h0051_0113);
        chk("if_mem_req_drop", {31'b0, mem_req}, 0);
        chk("if_stall_done", {31'b0, if_stall}, 0);
        mem_ack = 1'b0; if_req = 1'b0;
        tick();
        chk("if_valid_pulse", {31'b0, if_valid}, 0);

        // load then store: store must leave dm_rdata untouched
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        chk("ld_valid", {31'b0, dm_valid}, 1);
        chk("ld_rdata", dm_rdata, 32'h1234_5678);
        mem_ack = 1'b0; dm_req = 1'b0;
        tick();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hCAFE_F00D;
        tick();
        chk("st_mem_we", {31'b0, mem_we}, 1);
        chk("st_mem_addr", mem_addr, 32'h100);
        chk("st_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        chk("st_dm_stall", {31'b0, dm_stall}, 1);
        tick();
        chk("st_wait_req", {31'b0, mem_req}, 1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("st_valid", {31'b0, dm_valid}, 1);
        chk("st_rdata_kept", dm_rdata, 32'h1234_5678);
        mem_ack = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        tick();
        chk("st_valid_pulse", {31'b0, dm_valid}, 0);

        // both requesting continuously: four DM grants then IF forced through
        if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_addr = 32'h300;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("arb_addr", mem_addr, arb_addr[i]);
            chk("arb_if_stall", {31'b0, if_stall}, 1);
            mem_ack = 1'b1; mem_rdata = 32'(i);
            tick();
            chk("arb_valid", {30'b0, if_valid, dm_valid}, (i == 4) ? 32'd2 : 32'd1);
            mem_ack = 1'b0;
            if (i == 5) begin if_req = 1'b0; dm_req = 1'b0; end
        end
        chk("arb_if_rdata", if_rdata, 4);
        tick();

        // memory never answers: abort after 255 busy cycles
        if_req = 1'b1; if_addr = 32'h80; mem_rdata = 32'hFFFF_FFFF;
        tick();
        for (int i = 0; i < 254; i++) tick();
        chk("tmo_req_held", {31'b0, mem_req}, 1);
        chk("tmo_no_err_yet", {31'b0, bus_err}, 0);
        tick();
        chk("tmo_req_drop", {31'b0, mem_req}, 0);
        chk("tmo_valid", {31'b0, if_valid}, 1);
        chk("tmo_rdata", if_rdata, 0);
        chk("tmo_bus_err", {31'b0, bus_err}, 1);
        if_req = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'h84;
        tick();
        chk("post_tmo_addr", mem_addr, 32'h84);
        mem_ack = 1'b1; mem_rdata = 32'hABCD_0001;
        tick();
        chk("post_tmo_rdata", if_rdata, 32'hABCD_0001);
        chk("bus_err_sticky", {31'b0, bus_err}, 1);
        mem_ack = 1'b0; if_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("bus_err_reset", {31'b0, bus_err}, 0);

        // ack on the exact timeout cycle completes normally
        dm_req = 1'b1; dm_addr = 32'h400;
        tick();
        for (int i = 0; i < 254; i++) tick();
        mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
        tick();
        chk("edge_valid", {31'b0, dm_valid}, 1);
        chk("edge_rdata", dm_rdata, 32'h55AA_55AA);
        chk("edge_bus_err", {31'b0, bus_err}, 0);
        mem_ack = 1'b0; dm_req = 1'b0;
        tick();

        // reset two cycles into a load
        dm_req = 1'b1; dm_addr = 32'h500;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_req", {31'b0, mem_req}, 0);
        chk("mid_rst_valid", {31'b0, dm_valid}, 0);
        chk("mid_rst_rdata", dm_rdata, 0);
        chk("mid_rst_addr", mem_addr, 0);
`ifdef ARB_PERF_CNT_EN
        chk("perf_if_rst", perf_if_grants, 0);
        chk("perf_dm_rst", perf_dm_grants, 0);
        chk("perf_stall_rst", perf_stall_cycles, 0);
`endif
        reset = 1'b0; dm_req = 1'b0;
        tick();
        chk("post_rst_idle", {30'b0, mem_req, dm_valid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
